// File: rtl/alu_pkg.sv
// Shared opcode encodings and sequencing states for the ALU request arbiter.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: zero-extended operands, 2*W result, illegal-opcode flag and zero flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2:0]     op,
  output logic [2*W-1:0] result,
  output logic           zero,
  output logic           err
);

  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] b_ext;

  always_comb begin
    a_ext  = {{W{1'b0}}, a};
    b_ext  = {{W{1'b0}}, b};
    result = '0;
    err    = 1'b0;
    case (op)
      OP_ADD:  result = a_ext + b_ext;
      OP_SUB:  result = a_ext - b_ext;
      OP_AND:  result = a_ext & b_ext;
      OP_OR:   result = a_ext | b_ext;
      OP_MUL:  result = a_ext * b_ext;
      default: err    = 1'b1;
    endcase
    // zero follows the result computed here, so it can never lag the registered value
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared ALU with a one-deep response register.
//   state   | meaning
//   ST_IDLE | granting; req_ready driven to the round-robin winner
//   ST_EXEC | captured request evaluated, response registered at cycle end
//   ST_RESP | rsp_valid high, held until rsp_ready
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic [2:0]     req0_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  input  logic [2:0]     req1_op,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_result,
  output logic           rsp_zero,
  output logic           rsp_id,
  output logic           rsp_err
);

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]     op_q, op_d;
  logic           id_q, id_d;
  logic [2*W-1:0] result_q, result_d;
  logic           zero_q, zero_d;
  logic           err_q, err_d;
  logic           rsp_id_q, rsp_id_d;

  logic           gnt_id;
  logic           handshake;
  logic [2*W-1:0] core_result;
  logic           core_zero;
  logic           core_err;

  alu_core #(.W(W)) u_alu_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (core_result),
    .zero   (core_zero),
    .err    (core_err)
  );

  always_comb begin
    gnt_id    = (&req_valid) ? ~last_q : req_valid[1];
    req_ready = '0;
    if (state_q == ST_IDLE && (|req_valid)) req_ready[gnt_id] = 1'b1;
    handshake = |(req_valid & req_ready);

    state_d  = state_q;
    last_d   = last_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    id_d     = id_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    rsp_id_d = rsp_id_q;

    case (state_q)
      ST_IDLE: begin
        // round-robin state moves only on an actual handshake
        if (handshake) begin
          state_d = ST_EXEC;
          last_d  = gnt_id;
          id_d    = gnt_id;
          a_d     = gnt_id ? req1_a  : req0_a;
          b_d     = gnt_id ? req1_b  : req0_b;
          op_d    = gnt_id ? req1_op : req0_op;
        end
      end
      ST_EXEC: begin
        state_d  = ST_RESP;
        result_d = core_result;
        zero_d   = core_zero;
        err_d    = core_err;
        rsp_id_d = id_q;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      rsp_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      id_q     <= id_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;
  assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench: vector table plus contention, backpressure and reset sequences, scoreboarded.
module tb_alu_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_zero, rsp_id, rsp_err;

  alu_req_arbiter #(.W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       zero;
    logic       err;
    logic       id;
    int         hs_cyc;
  } exp_t;

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic       zero;
    logic       err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic rsp_valid_prev = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [3:0] a, input logic [3:0] b,
                                 input logic [2:0] op);
    exp_t e;
    logic [7:0] ax, bx;
    ax = {4'h0, a};
    bx = {4'h0, b};
    e.err = 1'b0;
    e.hs_cyc = 0;
    e.id = id;
    case (op)
      3'b000:  e.res = ax + bx;
      3'b001:  e.res = ax - bx;
      3'b010:  e.res = ax & bx;
      3'b011:  e.res = ax | bx;
      3'b100:  e.res = ax * bx;
      default: begin e.res = 8'h00; e.err = 1'b1; end
    endcase
    e.zero = (e.res == 8'h00);
    return e;
  endfunction

  // Response monitor: latency on each new response, payload on each accepted response.
  always @(negedge clk) begin
    if (rst_n) begin
      check("req_ready_onehot", {31'b0, (req_ready == 2'b11)}, 32'd0);
      if (rsp_valid && !rsp_valid_prev) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 result=0x%0h expected no response (cycle %0d)",
                   rsp_result, cyc);
        end else begin
          check("latency", cyc - sb[0].hs_cyc, 32'd2);
        end
      end
      if (rsp_valid && rsp_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_result", {24'b0, rsp_result}, {24'b0, e.res});
        check("rsp_zero", {31'b0, rsp_zero}, {31'b0, e.zero});
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        check("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
      end
    end
    rsp_valid_prev = rst_n ? rsp_valid : 1'b0;
  end

  task automatic issue(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                       input logic [7:0] er, input logic ez, input logic ee, output int waited);
    exp_t e;
    @(posedge clk); #1;
    if (id) begin req1_a = a; req1_b = b; req1_op = op; end
    else    begin req0_a = a; req0_b = b; req0_op = op; end
    req_valid[id] = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!req_ready[id] && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!req_ready[id]) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: got no req_ready for requester %0d expected a grant", id);
    end else begin
      e.res = er; e.zero = ez; e.err = ee; e.id = id; e.hs_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, sb.size(), 32'd0);
  endtask

  initial begin
    int   waited;
    int   got;
    int   n;
    logic ids[4];
    int   hcyc[4];
    exp_t e;

    vecs[0]  = '{1'b0, 4'hF, 4'h1, 3'b000, 8'h10, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'h3, 4'h5, 3'b001, 8'hFE, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'h7, 4'h7, 3'b001, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'hF, 4'hF, 3'b100, 8'hE1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'h3, 4'h2, 3'b110, 8'h00, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 4'hC, 4'hA, 3'b010, 8'h08, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'hC, 4'h3, 3'b011, 8'h0F, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'h0, 4'h0, 3'b000, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'h9, 4'h9, 3'b101, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 4'h4, 4'h1, 3'b111, 8'h00, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 4'h0, 4'h1, 3'b001, 8'hFF, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'hA, 4'h0, 3'b100, 8'h00, 1'b1, 1'b0};

    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    req0_a = 4'h0; req0_b = 4'h0; req0_op = 3'b000;
    req1_a = 4'h0; req1_b = 4'h0; req1_op = 3'b000;

    #12;
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_result", {24'b0, rsp_result}, 32'd0);
    check("reset_rsp_zero", {31'b0, rsp_zero}, 32'd0);
    check("reset_rsp_id", {31'b0, rsp_id}, 32'd0);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].zero, vecs[i].err, waited);
      check("grant_wait", waited, 32'd0);
      drain("vec_drain");
    end

    // Backpressure: response held for five cycles while requester 1 waits.
    rsp_ready = 1'b0;
    issue(1'b0, 4'h2, 4'h3, 3'b000, 8'h05, 1'b0, 1'b0, waited);
    req1_a = 4'h1; req1_b = 4'h6; req1_op = 3'b011;
    req_valid[1] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_rsp_result", {24'b0, rsp_result}, 32'h05);
      check("bp_rsp_id", {31'b0, rsp_id}, 32'd0);
      check("bp_req_ready", {30'b0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release_idle", {31'b0, rsp_valid}, 32'd0);
    check("bp_release_grant", {30'b0, req_ready}, 32'd2);
    e = model(1'b1, 4'h1, 4'h6, 3'b011);
    e.hs_cyc = cyc;
    if (req_ready[1]) sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain("bp_drain");

    // Reset during EXEC: in-flight request discarded, round robin returns to requester 0.
    issue(1'b0, 4'h5, 4'h6, 3'b000, 8'h0B, 1'b0, 1'b0, waited);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_exec_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_exec_rsp_result", {24'b0, rsp_result}, 32'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req0_a = 4'h2; req0_b = 4'h3; req0_op = 3'b100;
    req1_a = 4'h9; req1_b = 4'h4; req1_op = 3'b001;
    req_valid = 2'b11;
    #1;
    check("rst_first_grant", {30'b0, req_ready}, 32'd1);
    req_valid = 2'b00;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    check("rst_no_stale_rsp", n, 32'd0);

    // Contention straight after reset: grants alternate starting with requester 0.
    @(posedge clk); #1;
    req_valid = 2'b11;
    got = 0;
    n = 0;
    while (got < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (req_ready != 2'b00) begin
        ids[got]  = req_ready[1];
        hcyc[got] = cyc;
        e = req_ready[1] ? model(1'b1, req1_a, req1_b, req1_op) : model(1'b0, req0_a, req0_b, req0_op);
        e.hs_cyc = cyc;
        sb.push_back(e);
        got++;
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("cont_grants", got, 32'd4);
    if (got == 4) begin
      for (int i = 0; i < 4; i++) check("cont_order", {31'b0, ids[i]}, i % 2);
      for (int i = 1; i < 4; i++) check("cont_spacing", hcyc[i] - hcyc[i-1], 32'd3);
    end
    drain("cont_drain");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
